// File: rtl/tree_rr_report_arbiter.sv
// Round-robin arbiter that funnels NREQ leaf requesters onto one valid/ready
// report channel; the winning leaf's word and index are captured at grant time.
module tree_rr_report_arbiter #(
  parameter int unsigned NREQ = 16,
  parameter int unsigned DW   = 32,
  parameter int unsigned IDW  = 4,
  parameter int unsigned CW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IDW-1:0]      out_id,
  output logic                busy,
  output logic [CW-1:0]       xfer_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            out_valid_nxt;
  logic [DW-1:0]   out_data_nxt;
  logic [IDW-1:0]  out_id_nxt;
  logic            busy_nxt;
  logic [CW-1:0]   xfer_cnt_nxt;

  logic [DW-1:0]   words [NREQ];
  logic            found;
  logic [IDW-1:0]  win;

  for (genvar k = 0; k < NREQ; k++) begin : g_words
    assign words[k] = req_data[k*DW +: DW];
  end

  // First requester at or after ptr, scanning circularly (index wraps in IDW bits).
  always_comb begin
    logic [IDW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + IDW'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    gnt_nxt       = '0;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_id_nxt    = out_id;
    busy_nxt      = busy;
    xfer_cnt_nxt  = xfer_cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt       = NREQ'(1) << win;
          out_data_nxt  = words[win];
          out_id_nxt    = win;
          out_valid_nxt = 1'b1;
          busy_nxt      = 1'b1;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        // Word and index stay frozen until the reporter takes them.
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          ptr_nxt       = out_id + IDW'(1);
          xfer_cnt_nxt  = xfer_cnt + CW'(1);
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      busy      <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_id    <= out_id_nxt;
      busy      <= busy_nxt;
      xfer_cnt  <= xfer_cnt_nxt;
    end
  end

endmodule
